// File: rtl/arbiter_pkg.sv
// Shared arbitration helpers: default sizes, pointer width and the round-robin
// "first set bit after ptr" search used by both the arbiter and the dispatcher.
package arbiter_pkg;

  localparam int REQ_WIDTH_DEF = 4;
  localparam int DW_DEF        = 8;
  localparam int RR_MAX        = 32;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scans ptr+1 .. ptr+n (mod n). It walks downward so the nearest hit is the
  // last assignment. Returns -1 when nothing is set.
  function automatic int rr_first(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int sel;
    int idx;
    sel = -1;
    for (int k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      if (req[idx[4:0]]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dispatch_slot.sv
// One-entry channel register: a load wins over a drain, and data holds once the
// channel is empty or stalled.
module dispatch_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] beat,
  input  logic          drain,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= beat;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// 1-to-REQ_WIDTH round-robin fan-out with a one-entry register per channel.
// Define RR_DISPATCHER_DEST_EN to route each beat explicitly by dest_in.
module rr_dispatcher
  import arbiter_pkg::*;
#(
  parameter int REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [DW-1:0]               data_in,
`ifdef RR_DISPATCHER_DEST_EN
  input  logic [$clog2(REQ_WIDTH)-1:0] dest_in,
`endif
  output logic                        ready_out,
  output logic [REQ_WIDTH-1:0]        valid_out,
  output logic [REQ_WIDTH*DW-1:0]     data_out,
  input  logic [REQ_WIDTH-1:0]        ready_in
);

  localparam int PW = ptr_w(REQ_WIDTH);

  logic [REQ_WIDTH-1:0]         avail;
  logic [REQ_WIDTH-1:0]         load;
  logic [REQ_WIDTH-1:0]         valid_q;
  logic [REQ_WIDTH-1:0][DW-1:0] data_q;
  logic                         take;

  // A slot draining this cycle can accept a new beat in the same cycle.
  assign avail = ~valid_q | ready_in;

`ifdef RR_DISPATCHER_DEST_EN
  logic dest_ok;

  // Out-of-range destinations are accepted and silently dropped.
  assign dest_ok   = int'(dest_in) < REQ_WIDTH;
  assign ready_out = dest_ok ? avail[dest_in] : 1'b1;
  assign take      = rst && valid_in && ready_out;
`else
  logic [PW-1:0] ptr;
  int            gnt;

  always_comb gnt = rr_first(RR_MAX'(avail), int'(ptr), REQ_WIDTH);

  assign ready_out = |avail;
  assign take      = rst && valid_in && ready_out;

  // Reset points at the last channel so that channel 0 receives the first grant.
  always_ff @(posedge clk) begin
    if (!rst)      ptr <= PW'(REQ_WIDTH - 1);
    else if (take) ptr <= PW'(gnt);
  end
`endif

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_slot
`ifdef RR_DISPATCHER_DEST_EN
    assign load[i] = take && dest_ok && (int'(dest_in) == i);
`else
    assign load[i] = take && (gnt == i);
`endif

    dispatch_slot #(.DW(DW)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .beat  (data_in),
      .drain (ready_in[i]),
      .valid (valid_q[i]),
      .data  (data_q[i])
    );
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Randomized bench for rr_dispatcher against a per-channel slot/pointer model,
// plus directed scenarios with literal expectations.
module tb_rr_dispatcher;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            valid_in = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic [N-1:0]    ready_in = '0;
  logic            ready_out;
  logic [N-1:0]    valid_out;
  logic [N*DW-1:0] data_out;
`ifdef RR_DISPATCHER_DEST_EN
  logic [1:0]      dest_in = '0;
`endif

  rr_dispatcher #(.REQ_WIDTH(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
`ifdef RR_DISPATCHER_DEST_EN
    .dest_in   (dest_in),
`endif
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  bit            m_valid [N];
  logic [DW-1:0] m_data  [N];
  int            m_ptr = N - 1;
  int            last_grant = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit can_take(input int i, input logic [N-1:0] rdy);
    return !m_valid[i] || rdy[i];
  endfunction

  // One clock: compare held outputs, drive inputs, check ready_out, advance model.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] d,
                      input logic [N-1:0] rdy, input int dst);
    logic [N-1:0]    mv;
    logic [N*DW-1:0] md;
    int              g;
    bit              exp_ro;
    bit              take;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      mv[i]          = m_valid[i];
      md[i*DW +: DW] = m_data[i];
    end
    if (chk_en) begin
      chk("valid_out", 64'(valid_out), 64'(mv));
      chk("data_out", 64'(data_out), 64'(md));
    end
    rst = r; valid_in = v; data_in = d; ready_in = rdy;
    g = -1;
`ifdef RR_DISPATCHER_DEST_EN
    dest_in = dst[1:0];
    exp_ro  = (dst >= N) ? 1'b1 : can_take(dst, rdy);
    if (dst < N && exp_ro) g = dst;
`else
    for (int k = 1; k <= N; k++)
      if (g < 0 && can_take((m_ptr + k) % N, rdy)) g = (m_ptr + k) % N;
    exp_ro = (g >= 0);
`endif
    #1;
    if (chk_en) chk("ready_out", 64'(ready_out), 64'(exp_ro));
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_data[i] = '0; end
      m_ptr = N - 1;
      last_grant = -1;
    end else begin
      take = v && exp_ro;
      for (int i = 0; i < N; i++) begin
        if (take && i == g) begin m_valid[i] = 1'b1; m_data[i] = d; end
        else if (rdy[i]) m_valid[i] = 1'b0;
      end
`ifndef RR_DISPATCHER_DEST_EN
      if (take) m_ptr = g;
`endif
      last_grant = take ? g : -1;
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, '0, 0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, '0, '0, 0);
  endtask

  logic [DW-1:0] seq1 [4];
  logic [DW-1:0] seqa [4];

  initial begin
    for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_data[i] = '0; end
    do_reset();
    chk("reset valid", 64'(valid_out), 64'h0);
    chk("reset data", 64'(data_out), 64'h0);
    chk("reset ready", 64'(ready_out), 64'h1);

`ifdef RR_DISPATCHER_DEST_EN
    step(1'b1, 1'b1, 8'h5A, 4'b0000, 3);
    chk("dest valid", 64'(valid_out), 64'h8);
    chk("dest data", 64'(data_out), 64'h5A00_0000);
`else
    // Streaming into four free channels lands in order 0..3.
    seq1[0] = 8'h21; seq1[1] = 8'h43; seq1[2] = 8'h65; seq1[3] = 8'h87;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, seq1[k], 4'b1111, 0);
      chk("stream grant", 64'(last_grant), 64'(k));
    end
    chk("stream data", 64'(data_out), 64'h8765_4321);
    chk("stream valid", 64'(valid_out), 64'h8);

    // Channel 1 stuck full is skipped.
    do_reset();
    step(1'b1, 1'b1, 8'h01, 4'b1111, 0);
    step(1'b1, 1'b1, 8'h02, 4'b1101, 0);
    chk("fill ch1 grant", 64'(last_grant), 64'h1);
    seqa[0] = 8'hA0; seqa[1] = 8'hA1; seqa[2] = 8'hA2; seqa[3] = 8'hA3;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, seqa[k], 4'b1101, 0);
      chk("skip grant", 64'(last_grant), 64'((k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 0 : 2));
    end
    chk("skip data", 64'(data_out), 64'hA1A3_02A2);
    chk("skip valid", 64'(valid_out), 64'h6);

    // Fill all four, stall the fifth, then release channel 2.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'(8'hB0 + k), 4'b0000, 0);
    step(1'b1, 1'b1, 8'hB4, 4'b0000, 0);
    chk("stall ready", 64'(ready_out), 64'h0);
    chk("stall grant", 64'(last_grant), 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b1, 8'hB4, 4'b0100, 0);
    chk("release grant", 64'(last_grant), 64'h2);
    chk("release data", 64'(data_out), 64'hB3B4_B1B0);
    chk("release valid", 64'(valid_out), 64'hF);

    // Drain and reload of channel 0 in one cycle: no bubble.
    step(1'b1, 1'b1, 8'hC0, 4'b0001, 0);
    chk("reload grant", 64'(last_grant), 64'h0);
    chk("reload valid", 64'(valid_out), 64'hF);
    chk("reload data", 64'(data_out), 64'hB3B4_B1C0);

    // Mid-run reset discards held beats and restarts at channel 0.
    do_reset();
    step(1'b1, 1'b1, 8'h11, 4'b0000, 0);
    step(1'b1, 1'b1, 8'h22, 4'b0000, 0);
    step(1'b0, 1'b1, 8'h33, 4'b0000, 0);
    chk("mid reset valid", 64'(valid_out), 64'h0);
    chk("mid reset data", 64'(data_out), 64'h0);
    step(1'b1, 1'b1, 8'h44, 4'b0000, 0);
    chk("post reset grant", 64'(last_grant), 64'h0);
    chk("post reset data", 64'(data_out), 64'h44);
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 4'($urandom), $urandom_range(0, N - 1));
    end
    step(1'b1, 1'b0, '0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
